leiwand_rv32_bus_uart_tx: RTL

//  Bus responder for the core's mem_valid/mem_ready memory interface: a memory-mapped

---
 rtl/leiwand_rv32_bus_uart_tx.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/leiwand_rv32_bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the mem_valid/mem_ready bus: TX FIFO, status, divisor.
// One wait cycle per access; stores to a full FIFO are dropped and flagged in STATUS.overflow.
module leiwand_rv32_bus_uart_tx #(
  parameter int          XLEN        = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN-1:0]   mem_rdata,
  input  logic [XLEN/8-1:0] mem_wen,
  output logic              tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [XLEN-1:0] off;
  logic [1:0]      reg_idx;
  logic            sel, req, wr, push;
  logic            full, empty, busy, overflow;
  logic [15:0]     divisor, div_l, cnt;
  logic [AW:0]     wptr, rptr;
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [7:0]      shift;
  logic [2:0]      bitn;
  logic [XLEN-1:0] rd_val;
  logic            unused_bits;

  // Subtracting the base lets one upper-bits test cover both window bounds.
  assign off     = mem_addr - XLEN'(BASE_ADDR);
  assign reg_idx = off[3:2];
  assign sel     = mem_valid && (off[XLEN-1:4] == '0);
  assign req     = sel && !mem_ready;
  assign wr      = req && (mem_wen != '0);
  assign push    = wr && (reg_idx == 2'd0) && mem_wen[0];

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign busy  = (state != IDLE);

  assign unused_bits = ^{off[1:0], mem_wdata[XLEN-1:16]};

  always_comb begin
    rd_val = '0;
    case (reg_idx)
      2'd1:    rd_val[3:0]  = {overflow, busy, empty, full};
      2'd2:    rd_val[15:0] = divisor;
      default: rd_val       = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      overflow  <= 1'b0;
      divisor   <= DEFAULT_DIV;
      wptr      <= '0;
    end else begin
      mem_ready <= req;
      mem_rdata <= req ? rd_val : '0;
      if (push) begin
        if (full) overflow <= 1'b1;
        else      wptr     <= wptr + PTR_ONE;
      end
      if (wr && (reg_idx == 2'd1) && mem_wen[0] && mem_wdata[3])
        overflow <= 1'b0;
      if (wr && (reg_idx == 2'd2)) begin
        if (mem_wen[0]) divisor[7:0]  <= mem_wdata[7:0];
        if (mem_wen[1]) divisor[15:8] <= mem_wdata[15:8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      fifo_mem[wptr[AW-1:0]] <= mem_wdata[7:0];
  end

  // Divisor is latched per frame so register writes only affect the next frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rptr  <= '0;
      cnt   <= '0;
      bitn  <= '0;
      shift <= '0;
      div_l <= '0;
      tx    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            shift <= fifo_mem[rptr[AW-1:0]];
            rptr  <= rptr + PTR_ONE;
            div_l <= divisor;
            cnt   <= '0;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (cnt == div_l) begin
            cnt   <= '0;
            bitn  <= '0;
            tx    <= shift[0];
            state <= DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (cnt == div_l) begin
            cnt <= '0;
            if (bitn == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bitn  <= bitn + 3'd1;
              shift <= {1'b0, shift[7:1]};
              tx    <= shift[1];
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STOP: begin
          if (cnt == div_l) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
